// File: rtl/bit_serial_alu_pkg.sv
// Shared types and limits for the bit-serial ALU: op encodings, control states, width bounds.
package bsalu_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_SHL  = 3'b110,
    OP_ADC  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_alu_adder_cell.sv
// One-bit full adder with its carry flop; load seeds the carry before the first bit.
module bit_serial_adder_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic seed,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  logic c_q;
  logic c_d;

  always_comb begin
    sum  = a ^ b ^ c_q;
    cout = (a & b) | (a & c_q) | (b & c_q);
    c_d  = c_q;
    if (load) begin
      c_d = seed;
    end else if (en) begin
      c_d = cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: operands latched on start, processed LSB-first one bit per clock,
// parallel result and carry/zero flags published on the RUN->DONE edge.
module bit_serial_alu
  import bsalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("bit_serial_alu: WIDTH out of range");
  end

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zacc_q, zacc_d;
  logic             shl_q, shl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  op_e  op_in;
  logic accept;
  logic abit, bbit, rbit, cbit;
  logic cell_seed, cell_b, cell_sum, cell_cout;

  assign op_in  = op_e'(op);
  assign accept = (state_q == S_IDLE) && start;
  assign abit   = a_sh_q[0];
  assign bbit   = b_sh_q[0];
  // SUB runs as a + ~b + 1: invert B and seed the carry with 1; ADC seeds with the stored flag.
  assign cell_b    = (op_q == OP_SUB) ? ~bbit : bbit;
  assign cell_seed = (op_in == OP_SUB) | ((op_in == OP_ADC) & carry_q);

  bit_serial_adder_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (cell_seed),
    .en    (state_q == S_RUN),
    .a     (abit),
    .b     (cell_b),
    .sum   (cell_sum),
    .cout  (cell_cout)
  );

  always_comb begin
    rbit = abit;
    cbit = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_ADC: begin
        rbit = cell_sum;
        cbit = cell_cout;
      end
      OP_AND:  rbit = abit & bbit;
      OP_OR:   rbit = abit | bbit;
      OP_XOR:  rbit = abit ^ bbit;
      OP_PASS: rbit = abit;
      OP_SHL: begin
        rbit = shl_q;
        cbit = abit;
      end
      default: rbit = abit;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    zacc_d   = zacc_q;
    shl_d    = shl_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          op_d     = op_in;
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          cnt_d    = '0;
          zacc_d   = 1'b0;
          shl_d    = 1'b0;
        end
      end
      S_RUN: begin
        a_sh_d          = a_sh_q >> 1;
        b_sh_d          = b_sh_q >> 1;
        shl_d           = abit;
        res_sh_d[cnt_q] = rbit;
        zacc_d          = zacc_q | rbit;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = res_sh_d;
          carry_d  = cbit;
          zero_d   = ~(zacc_q | rbit);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      zacc_q   <= 1'b0;
      shl_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      zacc_q   <= zacc_d;
      shl_q    <= shl_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule
